// File: rtl/db_pkg.sv
// Shared deblocking definitions: LCU geometry and the QP-control sequencer state encoding.
package db_pkg;

    localparam int DB_LCU_WIDTH = 64;
    localparam int DB_BLK_W     = DB_LCU_WIDTH / 4;
    localparam int DB_ADDR_W    = 8;

    typedef enum logic [1:0] {
        DB_QPC_IDLE  = 2'd0,
        DB_QPC_RUN   = 2'd1,
        DB_QPC_DRAIN = 2'd2,
        DB_QPC_DONE  = 2'd3
    } db_qpc_state_e;

endpackage

// File: rtl/db_qp_eval.sv
// Per-block QP-modify evaluator: the flag is cleared by any coded residual, otherwise it
// inherits the left neighbour's flag. The enable freezes the result while the consumer stalls.
module db_qp_eval
    import db_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic cbf_y,
    input  logic cbf_u,
    input  logic cbf_v,
    input  logic left_flag,
    output logic qp_flag
);

    // register the evaluated flag; rst_n is an active-high synchronous reset
    always_ff @(posedge clk) begin
        if (rst_n) begin
            qp_flag <= 1'b0;
        end else if (en) begin
            qp_flag <= !(cbf_y | cbf_u | cbf_v) ? left_flag : 1'b0;
        end
    end

endmodule

// File: rtl/db_qp_ctrl.sv
// Deblocking QP-modify sequencer for one LCU. Scans the 4x4 blocks in raster order, reads their
// cbf flags, and emits one qp_flag per block. The right-column flags are kept in left_col_buf so
// the first column of the next LCU sees the correct left neighbour.
//
// Note: rst_n is an active-HIGH synchronous reset in this block.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start_i
//   RUN   | issuing one cbf read per advancing cycle
//   DRAIN | all reads issued; waiting for the last result to be taken
//   DONE  | one-cycle done_o pulse, back to IDLE
//
// Pipeline: read issue -> pending (store data arrives) -> result register. On a stall every
// stage freezes; the pending address is re-issued so the store keeps presenting its data,
// which is why cbf_rd_o/cbf_addr_o depend combinationally on flag_ready_i.
module db_qp_ctrl
    import db_pkg::*;
#(
    parameter int LCU_WIDTH = DB_LCU_WIDTH,
    parameter int ADDR_W    = DB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              lcu_x_i,
    input  logic              border_seed_i,
    output logic              cbf_rd_o,
    output logic [ADDR_W-1:0] cbf_addr_o,
    input  logic              cbf_y_i,
    input  logic              cbf_u_i,
    input  logic              cbf_v_i,
    output logic              flag_valid_o,
    input  logic              flag_ready_i,
    output logic [ADDR_W-1:0] flag_idx_o,
    output logic              qp_flag_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int BLK_W = LCU_WIDTH / 4;
    localparam int COL_W = $clog2(BLK_W);
    localparam int ROW_W = ADDR_W - COL_W;
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(BLK_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_W * BLK_W - 1);

    db_qpc_state_e     state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] scan_idx;
    logic              lcu_x_q;
    logic              seed_q;

    logic              pend_vld;
    logic [ADDR_W-1:0] pend_idx;
    logic [COL_W-1:0]  pend_col;
    logic [ROW_W-1:0]  pend_row;

    logic [BLK_W-1:0]  left_col_buf;
    logic              stall;
    logic              advance;
    logic              accept;
    logic              eval_en;
    logic              left_flag;

    assign scan_idx = {row, col};
    assign pend_col = pend_idx[COL_W-1:0];
    assign pend_row = pend_idx[ADDR_W-1:COL_W];

    assign stall   = flag_valid_o & ~flag_ready_i;
    assign advance = ~stall;
    assign accept  = flag_valid_o & flag_ready_i;
    assign eval_en = advance & pend_vld;

    // during a stall re-read the block whose data is pending so it is still there next cycle
    assign cbf_rd_o   = stall ? pend_vld : (state == DB_QPC_RUN);
    assign cbf_addr_o = stall ? pend_idx : scan_idx;

    // column 0 takes its left neighbour from the picture border seed or the previous LCU;
    // other columns forward the just-computed flag of the block to the left
    assign left_flag = (pend_col != '0) ? qp_flag_o
                     : (lcu_x_q ? seed_q : left_col_buf[pend_row]);

    // sequencing FSM with scan counters and registered busy/done
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= DB_QPC_IDLE;
            col     <= '0;
            row     <= '0;
            lcu_x_q <= 1'b0;
            seed_q  <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                DB_QPC_IDLE: begin
                    if (start_i) begin
                        state   <= DB_QPC_RUN;
                        lcu_x_q <= lcu_x_i;
                        seed_q  <= border_seed_i;
                        busy_o  <= 1'b1;
                    end
                end
                DB_QPC_RUN: begin
                    if (advance) begin
                        col <= col + COL_W'(1);
                        if (col == COL_MAX) begin
                            row <= row + ROW_W'(1);
                        end
                        if (scan_idx == LAST_IDX) begin
                            state <= DB_QPC_DRAIN;
                        end
                    end
                end
                DB_QPC_DRAIN: begin
                    if (accept && flag_idx_o == LAST_IDX) begin
                        state  <= DB_QPC_DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                DB_QPC_DONE: begin
                    state <= DB_QPC_IDLE;
                end
                default: begin
                    state <= DB_QPC_IDLE;
                end
            endcase
        end
    end

    // pending stage tracks the read in flight; result valid/index advance with the evaluator
    always_ff @(posedge clk) begin
        if (rst_n) begin
            pend_vld     <= 1'b0;
            pend_idx     <= '0;
            flag_valid_o <= 1'b0;
            flag_idx_o   <= '0;
        end else begin
            pend_vld <= cbf_rd_o;
            pend_idx <= cbf_addr_o;
            if (advance) begin
                flag_valid_o <= pend_vld;
                if (pend_vld) begin
                    flag_idx_o <= pend_idx;
                end
            end
        end
    end

    // store the right-column flag of each row once the consumer has taken it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            left_col_buf <= '0;
        end else if (accept && flag_idx_o[COL_W-1:0] == COL_MAX) begin
            left_col_buf[flag_idx_o[ADDR_W-1:COL_W]] <= qp_flag_o;
        end
    end

    db_qp_eval u_eval (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (eval_en),
        .cbf_y     (cbf_y_i),
        .cbf_u     (cbf_u_i),
        .cbf_v     (cbf_v_i),
        .left_flag (left_flag),
        .qp_flag   (qp_flag_o)
    );

endmodule

// File: tb/tb_db_qp_ctrl.sv
// Directed bench for db_qp_ctrl: a behavioural cbf store, a reference model that fills a
// scoreboard queue before each LCU, and result/timing checks as the DUT delivers.
module tb_db_qp_ctrl;
    import db_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       lcu_x_i;
    logic       border_seed_i;
    logic       cbf_rd_o;
    logic [7:0] cbf_addr_o;
    logic       cbf_y_i;
    logic       cbf_u_i;
    logic       cbf_v_i;
    logic       flag_valid_o;
    logic       flag_ready_i;
    logic [7:0] flag_idx_o;
    logic       qp_flag_o;
    logic       busy_o;
    logic       done_o;

    typedef struct {
        logic [7:0] idx;
        logic       flag;
    } exp_t;

    exp_t        exp_q[$];
    logic        mem_y[256];
    logic        mem_u[256];
    logic        mem_v[256];
    logic [15:0] mbuf;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    db_qp_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .lcu_x_i       (lcu_x_i),
        .border_seed_i (border_seed_i),
        .cbf_rd_o      (cbf_rd_o),
        .cbf_addr_o    (cbf_addr_o),
        .cbf_y_i       (cbf_y_i),
        .cbf_u_i       (cbf_u_i),
        .cbf_v_i       (cbf_v_i),
        .flag_valid_o  (flag_valid_o),
        .flag_ready_i  (flag_ready_i),
        .flag_idx_o    (flag_idx_o),
        .qp_flag_o     (qp_flag_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // cbf store: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (cbf_rd_o) begin
            cbf_y_i <= mem_y[cbf_addr_o];
            cbf_u_i <= mem_u[cbf_addr_o];
            cbf_v_i <= mem_v[cbf_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_cbf(input int mode);
        for (int i = 0; i < 256; i++) begin
            mem_y[i] = 1'b0;
            mem_u[i] = 1'b0;
            mem_v[i] = 1'b0;
            if (mode == 1) begin
                mem_y[i] = ($urandom_range(0, 7) == 0);
                mem_u[i] = ($urandom_range(0, 7) == 0);
                mem_v[i] = ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic build_expected(input logic lx, input logic sd);
        logic prev;
        logic left;
        logic f;
        int   r;
        int   c;
        prev = 1'b0;
        for (int i = 0; i < 256; i++) begin
            r = i / 16;
            c = i % 16;
            if (c == 0) left = lx ? sd : mbuf[r];
            else        left = prev;
            f = (mem_y[i] | mem_u[i] | mem_v[i]) ? 1'b0 : left;
            exp_q.push_back('{idx: 8'(i), flag: f});
            prev = f;
            if (c == 15) mbuf[r] = f;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rd"},    cbf_rd_o,     0);
        chk({tag, "_addr"},  cbf_addr_o,   0);
        chk({tag, "_valid"}, flag_valid_o, 0);
        chk({tag, "_idx"},   flag_idx_o,   0);
        chk({tag, "_flag"},  qp_flag_o,    0);
        chk({tag, "_busy"},  busy_o,       0);
        chk({tag, "_done"},  done_o,       0);
        chk({tag, "_state"}, dut.state,    DB_QPC_IDLE);
        chk({tag, "_buf"},   dut.left_col_buf, 0);
    endtask

    task automatic run_lcu(input logic lx, input logic sd, input int stall_idx,
                           input int stall_len, input int rst_idx, input int extra_start,
                           input int exp_done);
        int   cyc;
        int   stall_cnt;
        bit   done_seen;
        bit   aborted;
        exp_t e;
        build_expected(lx, sd);
        @(posedge clk); #1;
        start_i       = 1'b1;
        lcu_x_i       = lx;
        border_seed_i = sd;
        @(posedge clk); #1;
        start_i       = 1'b0;
        lcu_x_i       = ~lx;
        border_seed_i = ~sd;
        chk("busy_after_start", busy_o, 1);
        cyc       = 0;
        stall_cnt = 0;
        done_seen = 0;
        aborted   = 0;
        while (!done_seen && !aborted && cyc < 600) begin
            @(posedge clk);
            cyc++;
            #1;
            flag_ready_i = 1'b1;
            if (flag_valid_o && flag_idx_o == 8'(stall_idx) && stall_cnt < stall_len) begin
                flag_ready_i = 1'b0;
                stall_cnt++;
            end
            start_i = (cyc == extra_start);
            #1;
            if (!flag_ready_i) begin
                chk("stall_rd", cbf_rd_o, 1);
                chk("stall_addr", cbf_addr_o, stall_idx + 1);
            end
            if (flag_valid_o && flag_ready_i) begin
                chk("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("res_idx", flag_idx_o, e.idx);
                    chk("res_flag", qp_flag_o, e.flag);
                end
                if (int'(flag_idx_o) == rst_idx) begin
                    rst_n   = 1'b1;
                    aborted = 1;
                end
            end
            if (done_o) begin
                done_seen = 1;
                chk("done_cycle", cyc, exp_done);
            end
        end
        start_i = 1'b0;
        flag_ready_i = 1'b1;
        if (aborted) begin
            @(posedge clk); #2;
            check_idle_outputs("mid_reset");
            rst_n = 1'b0;
            exp_q.delete();
            mbuf = '0;
        end else begin
            chk("done_seen", done_seen, 1);
            chk("busy_at_done", busy_o, 0);
            chk("sb_drained", exp_q.size(), 0);
            chk("left_col_buf", dut.left_col_buf, mbuf);
            @(posedge clk); #2;
            chk("done_pulse_end", done_o, 0);
            chk("idle_after_done", dut.state, DB_QPC_IDLE);
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        start_i       = 1'b0;
        lcu_x_i       = 1'b0;
        border_seed_i = 1'b0;
        flag_ready_i  = 1'b1;
        mbuf          = '0;
        set_cbf(0);
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        rst_n = 1'b0;

        // 1: empty LCU at the left border, seed 1
        set_cbf(0);
        run_lcu(1'b1, 1'b1, -1, 0, -1, -1, 258);
        chk("t1_buf", dut.left_col_buf, 16'hFFFF);

        // 2: seed 0
        run_lcu(1'b1, 1'b0, -1, 0, -1, -1, 258);
        chk("t2_buf", dut.left_col_buf, 16'h0000);

        // 3: one coded block at idx 5
        set_cbf(0);
        mem_y[5] = 1'b1;
        run_lcu(1'b1, 1'b1, -1, 0, -1, -1, 258);
        chk("t3_buf", dut.left_col_buf, 16'hFFFE);

        // 4: interior LCU inherits the previous right column, seed ignored
        set_cbf(0);
        run_lcu(1'b0, 1'b1, -1, 0, -1, -1, 258);

        // 5: three-cycle consumer stall at idx 40
        run_lcu(1'b1, 1'b1, 40, 3, -1, -1, 261);

        // random cbf pattern on an interior LCU
        set_cbf(1);
        run_lcu(1'b0, 1'b0, -1, 0, -1, -1, 258);

        // 6: reset at idx 100, then a clean restart with a stray start during busy
        set_cbf(0);
        run_lcu(1'b1, 1'b1, -1, 0, 100, -1, 258);
        run_lcu(1'b0, 1'b1, -1, 0, -1, 50, 258);
        chk("t6_buf", dut.left_col_buf, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
